// File: rtl/csa_addsub_pipe_if.sv
// Purpose: operand/result handshake bundle for the carry-select add/sub pipe.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready follow valid/ready rules; a beat moves when valid && ready.
//
// Signals
//   in_valid/in_ready  operand beat handshake (upstream -> unit)
//   sub, a, b, cin     operation select, operands, carry/borrow in
//   out_valid/out_ready result beat handshake (unit -> downstream)
//   s, cout, ovf, zero result and status flags
// Modports: master = upstream/downstream side (bench), slave = the unit.
interface csa_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, sub, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, sub, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/csa_addsub_pipe.sv
// Purpose: 2-stage carry-select add / subtract-with-borrow with registered status flags.
// Latency: 2 cycles accept-to-out_valid, 1 beat/cycle throughput when not stalled.
// Backpressure: stage 2 holds while out_valid && !out_ready; stage 1 fills once, then in_ready drops.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; drops every in-flight beat
//   bus    csa_addsub_pipe_if.slave: operand beat in, result beat out
//          {cout,s} = a + (sub ? ~b : b) + (sub ? ~cin : cin)
//          cout is NOT-borrow for subtract; ovf is signed overflow; zero is s == 0
module csa_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  csa_addsub_pipe_if.slave    bus
);

  localparam int HW = WIDTH - SPLIT;

  // Everything stage 2 needs to finish the add without touching the operands again.
  typedef struct packed {
    logic [SPLIT-1:0] s_lo;
    logic             c_lo;
    logic [HW-1:0]    h0;
    logic             c0;
    logic [HW-1:0]    h1;
    logic             c1;
    logic             a_msb;
    logic             b_msb;
  } st1_t;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [SPLIT:0]   lo_sum;
  logic [HW:0]      hi_sum0;
  logic [HW:0]      hi_sum1;
  st1_t             st1_d;
  st1_t             st1_q;

  logic             v1;
  logic             v2;
  logic             adv2;
  logic             acc;
  logic             in_rdy;

  logic [HW-1:0]    h_sel;
  logic             c_sel;
  logic [WIDTH-1:0] s_d;
  logic             ovf_d;

  // ---------------------------------------------------------------------------
  // Stage 1: low segment sum and both high-segment candidates.
  // Subtract is a + ~b + ~cin, so a borrow-in of 1 becomes a carry-in of 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    b_eff   = bus.sub ? ~bus.b : bus.b;
    c_eff   = bus.sub ? ~bus.cin : bus.cin;

    lo_sum  = {1'b0, bus.a[SPLIT-1:0]} + {1'b0, b_eff[SPLIT-1:0]}
            + {{SPLIT{1'b0}}, c_eff};

    // Two independent high adders: one assumes no carry from the low
    // segment, the other assumes a carry. Stage 2 only picks one.
    hi_sum0 = {1'b0, bus.a[WIDTH-1:SPLIT]} + {1'b0, b_eff[WIDTH-1:SPLIT]};
    hi_sum1 = {1'b0, bus.a[WIDTH-1:SPLIT]} + {1'b0, b_eff[WIDTH-1:SPLIT]}
            + {{HW{1'b0}}, 1'b1};

    st1_d       = '0;
    st1_d.s_lo  = lo_sum[SPLIT-1:0];
    st1_d.c_lo  = lo_sum[SPLIT];
    st1_d.h0    = hi_sum0[HW-1:0];
    st1_d.c0    = hi_sum0[HW];
    st1_d.h1    = hi_sum1[HW-1:0];
    st1_d.c1    = hi_sum1[HW];
    // Operand sign bits are kept so overflow can be judged after the select.
    st1_d.a_msb = bus.a[WIDTH-1];
    st1_d.b_msb = b_eff[WIDTH-1];
  end

  // ---------------------------------------------------------------------------
  // Stage 2: carry select. The low carry only steers a mux; it never ripples
  // into the high adder.
  // ---------------------------------------------------------------------------
  always_comb begin
    h_sel = st1_q.c_lo ? st1_q.h1 : st1_q.h0;
    c_sel = st1_q.c_lo ? st1_q.c1 : st1_q.c0;
    s_d   = {h_sel, st1_q.s_lo};
    ovf_d = (st1_q.a_msb == st1_q.b_msb) && (s_d[WIDTH-1] != st1_q.a_msb);
  end

  // ---------------------------------------------------------------------------
  // Handshake. in_ready looks only at pipeline state, never at in_valid, so
  // upstream can compute valid from ready without a combinational loop.
  // ---------------------------------------------------------------------------
  assign adv2          = v1 && (!v2 || bus.out_ready);
  assign in_rdy        = !v1 || adv2;
  assign acc           = bus.in_valid && in_rdy;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = v2;

  // Data registers load only on their own enable, so the visible result is
  // frozen across stalls and bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      st1_q    <= '0;
      bus.s    <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      if (acc) begin
        st1_q <= st1_d;
      end

      if (acc) begin
        v1 <= 1'b1;
      end else if (adv2) begin
        v1 <= 1'b0;
      end

      if (adv2) begin
        bus.s    <= s_d;
        bus.cout <= c_sel;
        bus.ovf  <= ovf_d;
        bus.zero <= (s_d == '0);
      end

      if (adv2) begin
        v2 <= 1'b1;
      end else if (bus.out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule

// File: doc/csa_addsub_pipe.md
Name: csa_addsub_pipe

Overview:
- 2-stage pipelined, carry-select add/subtract unit with valid/ready handshake on both sides.
- Consumes the same operand set as the combinational carry-select adder: A, B and carry-in.
- Adds the reverse operation (subtract with borrow) and registered status flags.
- Sits between the FPU mantissa datapath and the normaliser/shifter; produces one result per cycle when not stalled.

Parameters:
- WIDTH, 16, operand/result width; must be even.
- SPLIT, 8, width of the low carry-select segment; 1 <= SPLIT < WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept operand beat.
- sub  input  1  0 = add, 1 = subtract.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  result.
- cout  output  1  carry-out (add); NOT-borrow (sub).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

Behaviour:
- Reset: rst_n sampled low at a clock edge clears both stage-valid bits.
  - out_valid = 0.
  - s, cout, ovf and zero are reset to 0.
  - in_ready = 1 in the first cycle after reset is released.
- Reset mid-operation discards all in-flight beats; no beat is emitted afterwards.
- Arithmetic:
  - Effective operand b' = sub ? ~b : b.
  - Effective carry c' = sub ? ~cin : cin.
  - {cout,s} = a + b' + c', computed modulo 2^(WIDTH+1).
  - For sub: s = a - b - cin, and cout = 1 iff a >= b + cin (unsigned).
- Flags:
  - ovf = (a[MSB] == b'[MSB]) && (s[MSB] != a[MSB]).
  - zero = (s == 0).
- Stage 1 (registered on input accept):
  - Low segment sum {c_lo, s_lo} = a[SPLIT-1:0] + b'[SPLIT-1:0] + c'.
  - High-segment candidates {c0, h0} = a_hi + b'_hi + 0 and {c1, h1} = a_hi + b'_hi + 1.
  - a_hi[MSB] and b'_hi[MSB] are registered for the overflow computation.
- Stage 2 (registered on advance):
  - Select h = c_lo ? h1 : h0 and cout = c_lo ? c1 : c0.
  - s = {h, s_lo}; compute ovf and zero.
  - No carry ripples across the segment boundary.
- Handshake:
  - A beat transfers when valid && ready are both high at a clock edge.
  - adv2 = v1 && (!v2 || out_ready).
  - in_ready = !v1 || adv2 (combinational, no in_valid dependency).
  - v2 next = adv2 ? 1 : (out_ready ? 0 : v2).
  - v1 next = (in_valid && in_ready) ? 1 : (adv2 ? 0 : v1).
  - Simultaneous accept and advance both happen in the same cycle.
- Latency: 2 cycles from input accept to out_valid with no stall. Throughput: 1 beat/cycle.
- Stall: while out_valid && !out_ready, s/cout/ovf/zero hold stable and stage 2 does not change.
  - Stage 1 may still fill once; with both stages full, in_ready = 0.
  - Up to 2 beats are buffered.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Stage registers load only on their enable, so outputs never glitch while out_valid = 0.

Test Plan:
- Reset/idle: hold rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, s = 0; after release in_ready = 1 and no spurious output.
- Add across carry-select boundary: a = 0x00FF, b = 0x0001, cin = 0, sub = 0 -> 2 cycles later s = 0x0100, cout = 0, ovf = 0, zero = 0.
- Add full overflow: a = 0xFFFF, b = 0x0001, cin = 0 -> s = 0x0000, cout = 1, zero = 1. Then a = 0x7FFF, b = 0x0001 -> s = 0x8000, ovf = 1.
- Subtract with borrow:
  - a = 0x1000, b = 0x0001, cin = 0, sub = 1 -> s = 0x0FFF, cout = 1.
  - a = 0x0000, b = 0x0000, cin = 1, sub = 1 -> s = 0xFFFF, cout = 0.
  - a = 0x8000, b = 0x0001, sub = 1 -> ovf = 1.
- Backpressure: stream 4 beats (i = 1..4: a = i, b = 16 * i) with out_ready low for cycles 3-6 -> in_ready drops after 2 beats are buffered, s holds at 0x0011 while stalled, then 0x0011, 0x0022, 0x0033, 0x0044 are emitted in order with no loss.
- Exhaustive-low sweep: a, b in 0..255, cin in {0, 1}, sub in {0, 1}, back-to-back with out_ready = 1 -> every {cout,s} matches the arithmetic rule; error count = 0.
